// File: rtl/pacote_display.sv
// pacote_display: segment constants and default timing for the multiplexed 7-segment scanner
package pacote_display;
  localparam int DIV_PADRAO = 50000;
  localparam int BLANK_PADRAO = 500;
  localparam logic [6:0] SEG_APAGADO = 7'b1111111;
  localparam logic [6:0] SEG_TRACO = 7'b0111111;
  localparam logic [6:0] SEG_DIGITO [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };
endpackage

// File: rtl/varredura_display_decodificador.sv
// decodificador_bcd_7seg: BCD nibble to active-low {g,f,e,d,c,b,a}, dash for A-F
module decodificador_bcd_7seg
  import pacote_display::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);
  assign seg = (bcd > 4'd9) ? SEG_TRACO : SEG_DIGITO[bcd];
endmodule

// File: rtl/varredura_display.sv
// varredura_display: 4-digit multiplexed 7-segment scanner with anode guard time and frame-latched inputs
module varredura_display
  import pacote_display::*;
#(
  parameter int DIV = DIV_PADRAO,
  parameter int BLANK = BLANK_PADRAO
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] digitos,
  input  logic [3:0]  pontos,
  input  logic        blank_zero,
  output logic [3:0]  anodo,
  output logic [6:0]  segmentos,
  output logic        ponto,
  output logic        quadro
);
  localparam int W = $clog2(DIV);
  localparam logic [W-1:0] CNT_MAX = W'(DIV - 1);
  localparam logic [W-1:0] CNT_BLANK = W'(BLANK);
  if (DIV < 2 || BLANK < 1 || BLANK >= DIV) begin : g_param_invalido
    $error("varredura_display: need DIV >= 2 and 1 <= BLANK < DIV");
  end
  logic [W-1:0] cnt;
  logic [1:0]   idx;
  logic [15:0]  sh_dig;
  logic [3:0]   sh_pt;
  logic         sh_bz;
  logic         tick;
  logic         guarda;
  logic [3:0]   zero;
  logic [3:0]   apaga;
  logic [3:0]   dig_sel;
  logic [6:0]   seg_dec;
  assign tick = cnt == CNT_MAX;
  assign guarda = cnt < CNT_BLANK;
  assign zero = {sh_dig[15:12] == 4'd0, sh_dig[11:8] == 4'd0, sh_dig[7:4] == 4'd0, sh_dig[3:0] == 4'd0};
  assign apaga = {sh_bz & zero[3], sh_bz & (&zero[3:2]), sh_bz & (&zero[3:1]), 1'b0};
  assign dig_sel = sh_dig[{idx, 2'b00} +: 4];
  decodificador_bcd_7seg u_dec (
    .bcd (dig_sel),
    .seg (seg_dec)
  );
  // prescaler and slot index: one slot is DIV cycles, four slots make a frame
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      cnt <= '0;
      idx <= '0;
    end else begin
      cnt <= tick ? '0 : cnt + 1'b1;
      idx <= tick ? idx + 1'b1 : idx;
    end
  // shadow copy taken only at frame start so a frame never mixes old and new inputs
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      sh_dig <= '0;
      sh_pt  <= '0;
      sh_bz  <= 1'b0;
    end else if (cnt == '0 && idx == 2'd0) begin
      sh_dig <= digitos;
      sh_pt  <= pontos;
      sh_bz  <= blank_zero;
    end
  // registered drives: everything dark during the guard window, then the selected digit
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      anodo     <= 4'b1111;
      segmentos <= SEG_APAGADO;
      ponto     <= 1'b1;
      quadro    <= 1'b0;
    end else begin
      anodo     <= guarda ? 4'b1111 : ~(4'b0001 << idx);
      segmentos <= (guarda || apaga[idx]) ? SEG_APAGADO : seg_dec;
      ponto     <= guarda | ~sh_pt[idx];
      quadro    <= tick && idx == 2'd3;
    end
endmodule

// File: tb/tb_varredura_display.sv
// tb_varredura_display: directed scoreboard bench for the 7-segment scanner at DIV=4, BLANK=1
module tb_varredura_display;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] digitos = '0;
  logic [3:0]  pontos = '0;
  logic        blank_zero = 1'b0;
  logic [3:0]  anodo;
  logic [6:0]  segmentos;
  logic        ponto;
  logic        quadro;
  typedef struct {
    logic [12:0] v;
    string       tag;
  } esp_t;
  esp_t fila[$];
  int   pulsos[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   ciclo = 0;
  varredura_display #(.DIV(4), .BLANK(1)) dut (
    .clock      (clock),
    .reset      (reset),
    .digitos    (digitos),
    .pontos     (pontos),
    .blank_zero (blank_zero),
    .anodo      (anodo),
    .segmentos  (segmentos),
    .ponto      (ponto),
    .quadro     (quadro)
  );
  always #5 clock = ~clock;
  function automatic logic [6:0] seg_de(input logic [3:0] n);
    case (n)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction
  task automatic checa(input string tag, input logic [12:0] obs, input logic [12:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask
  // one frame of expectations from the inputs being presented now
  task automatic empilha(input string nome);
    for (int p = 0; p < 16; p++) begin
      int s = p / 4;
      logic [3:0] an = 4'b1111;
      logic [6:0] sg = 7'b1111111;
      logic pt = 1'b1;
      logic [15:0] alto = digitos >> (4 * s);
      if (p % 4 != 0) begin
        an = ~(4'b0001 << s);
        sg = (blank_zero && s > 0 && alto == 16'd0) ? 7'b1111111 : seg_de(alto[3:0]);
        pt = ~pontos[s];
      end
      fila.push_back('{v: {an, sg, pt, p == 15}, tag: $sformatf("%s_p%0d", nome, p)});
    end
  endtask
  task automatic passo(input int n);
    for (int i = 0; i < n; i++) begin
      esp_t e;
      @(posedge clock);
      @(negedge clock);
      ciclo++;
      if (quadro) pulsos.push_back(ciclo);
      if (fila.size() == 0) begin
        miscompares++;
        $error("FAIL scoreboard_empty: observed no entry expected one at cycle %0d", ciclo);
      end else begin
        e = fila.pop_front();
        checa(e.tag, {anodo, segmentos, ponto, quadro}, e.v);
      end
    end
  endtask
  initial begin
    #1 reset = 1'b1;
    #1 checa("reset_init", {anodo, segmentos, ponto, quadro}, {4'b1111, 7'b1111111, 1'b1, 1'b0});
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    digitos = 16'h1234; pontos = 4'b0000; blank_zero = 1'b0;
    empilha("h1234");
    passo(16);
    digitos = 16'h0005; blank_zero = 1'b1;
    empilha("h0005_bz");
    passo(16);
    pulsos.delete();
    digitos = 16'h00A0; pontos = 4'b0100; blank_zero = 1'b0;
    empilha("h00A0_dp2");
    passo(16);
    digitos = 16'h1111; pontos = 4'b0000;
    empilha("h1111_tear");
    passo(9);
    digitos = 16'h2222;
    passo(7);
    empilha("h2222");
    passo(16);
    checa("quadro_count", 13'(pulsos.size()), 13'd3);
    if (pulsos.size() == 3) begin
      checa("quadro_gap1", 13'(pulsos[1] - pulsos[0]), 13'd16);
      checa("quadro_gap2", 13'(pulsos[2] - pulsos[1]), 13'd16);
    end
    digitos = 16'h1234; pontos = 4'b0000;
    empilha("pre_reset");
    passo(10);
    #1 reset = 1'b1;
    #1 checa("reset_async", {anodo, segmentos, ponto, quadro}, {4'b1111, 7'b1111111, 1'b1, 1'b0});
    fila.delete();
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    digitos = 16'h9870; pontos = 4'b0001; blank_zero = 1'b1;
    empilha("restart_h9870");
    passo(16);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/varredura_display.md
VARREDURA_DISPLAY -- requirements
Module: varredura_display

Interface
REQ-001 Parameter DIV, default 50000: clock cycles per digit slot; legal range DIV >= 2.
REQ-002 Parameter BLANK, default 500: anode-off guard cycles at the start of each slot; legal range 1 <= BLANK < DIV.
REQ-003 Port clock  in  1  single system clock; all state updates on its rising edge.
REQ-004 Port reset  in  1  asynchronous, active-high reset.
REQ-005 Port digitos  in  16  four BCD digits; [3:0] is digit 0 (rightmost), [15:12] is digit 3 (leftmost).
REQ-006 Port pontos  in  4  decimal-point enable per digit, bit k belongs to digit k, 1 = lit.
REQ-007 Port blank_zero  in  1  1 = leading-zero blanking enabled.
REQ-008 Port anodo  out  4  digit enables, active-low, bit k drives digit k.
REQ-009 Port segmentos  out  7  segment drives, active-low, bit order {g,f,e,d,c,b,a}.
REQ-010 Port ponto  out  1  decimal-point drive, active-low.
REQ-011 Port quadro  out  1  one-cycle high pulse marking the start of each scan frame.

Function
REQ-012 The prescaler cnt SHALL count 0..DIV-1 and wrap to 0; tick is asserted when cnt == DIV-1.
REQ-013 The slot index idx (2 bits) SHALL increment on tick and wrap from 3 to 0.
REQ-014 The shadow register SHALL load digitos, pontos and blank_zero in every cycle where cnt == 0 and idx == 0, including the first cycle after reset release.
REQ-015 Input changes outside a shadow load SHALL NOT affect the display until the next frame (no tearing).
REQ-016 All outputs SHALL be registered: outputs in cycle t+1 are a function of cnt, idx and shadow in cycle t.
REQ-017 While cnt < BLANK, anodo SHALL be 4'b1111, segmentos SHALL be 7'b1111111 and ponto SHALL be 1.
REQ-018 While cnt >= BLANK, anodo SHALL have only bit idx low, and segmentos and ponto SHALL decode shadow digit idx.
REQ-019 BCD 0-9 SHALL use the standard encoding (0 = 7'b1000000, 1 = 7'b1111001, 4 = 7'b0011001, 5 = 7'b0010010).
REQ-020 Nibble values A-F SHALL display a dash, 7'b0111111.
REQ-021 With shadow blank_zero = 1, digit k (k = 3, 2, 1) SHALL show 7'b1111111 when it and all higher digits are 0; digit 0 is never blanked.
REQ-022 Blanking SHALL affect segmentos only; the anode still enables and ponto still follows pontos.
REQ-023 quadro SHALL be 1 for exactly one cycle, in the cycle after idx wraps from 3 to 0.

Reset
REQ-024 Reset assertion SHALL set cnt = 0, idx = 0, shadow = 0, anodo = 4'b1111, segmentos = 7'b1111111, ponto = 1 and quadro = 0 immediately, without waiting for a clock edge.
REQ-025 After reset release, scanning SHALL restart at slot 0 with cnt = 0.

Structure
REQ-026 Package pacote_display SHALL hold the segment constants (SEG_APAGADO, SEG_TRACO and the 0-9 table) and the default values of DIV and BLANK.
REQ-027 BCD decoding SHALL be a combinational sub-module, decodificador_bcd_7seg (4-bit in, 7-bit active-low out).
REQ-028 An illegal DIV or BLANK value SHALL cause an elaboration-time error.

Verification (DIV = 4, BLANK = 1)
REQ-029 Assert reset mid-slot 2 with digit lit -> anodo = 1111, segmentos = 1111111, ponto = 1 before the next edge; after release the scan restarts at slot 0.
REQ-030 digitos = 16'h1234, blank_zero = 0 -> per 4-cycle slot, 1 cycle all-off then 3 cycles lit: slot 0 anodo = 1110 / seg = 0011001, ..., slot 3 anodo = 0111 / seg = 1111001.
REQ-031 digitos = 16'h0005, blank_zero = 1 -> slots 3, 2 and 1 show seg = 1111111 with their anode low; slot 0 shows 0010010.
REQ-032 digitos = 16'h00A0 -> slot 1 shows 0111111; pontos = 4'b0100 -> ponto = 0 only during slot 2's lit cycles.
REQ-033 Change digitos from 16'h1111 to 16'h2222 during slot 2 -> slots 2 and 3 still show 1; the next frame shows 2 in all slots.
REQ-034 Run 3 frames -> quadro pulses exactly 3 times, 16 cycles apart, each one cycle long.
